siso_frame_ctrl: RTL and testbench
==================================

Name: siso_frame_ctrl

Overview:
- Controller that sequences a serial-in/serial-out shift datapath as a framed serial transmitter.
- Accepts parallel words over a valid/ready handshake and drives one serial line: start bit, WIDTH data bits MSB first, stop bit.
- Paces each bit with a programmable bit-period counter.
- Sits between a parallel producer and the SISO shift chain / serial link.

Parameters:
- WIDTH, 8, data bits per frame (2..32).
- BIT_CYCLES, 1, clock cycles each serial bit is held (1..255).

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  producer has a word on in_data.
- in_data  input  WIDTH  parallel word to transmit.
- in_ready  output  1  controller can accept a word this cycle.
- s_out  output  1  serial line, registered; idles high.
- busy  output  1  high while a frame is in progress (any state other than IDLE).
- done  output  1  one-cycle pulse when a frame completes.

Behaviour:
- Reset (rst=1 at a clock edge): state=IDLE, s_out=1, in_ready=1, busy=0, done=0, bit and cycle counters=0, shift register=0. Reset overrides any in-progress frame; the partial frame is abandoned, with no done pulse.
- States: IDLE -> START -> DATA -> STOP -> IDLE (PARITY inserted between DATA and STOP when the optional feature is on).
- IDLE:
  - in_ready=1, s_out=1.
  - Handshake occurs when in_valid && in_ready at an edge: in_data is latched into the shift register and the state becomes START.
  - in_data is not sampled at any other time.
- START: s_out=0 for BIT_CYCLES cycles.
- DATA:
  - s_out = shift register MSB.
  - Every BIT_CYCLES cycles, shift left by one and increment the bit counter.
  - After WIDTH bits, go to STOP.
- STOP:
  - s_out=1 for BIT_CYCLES cycles, then go to IDLE.
  - done=1 for exactly one cycle, the first cycle back in IDLE.
- Outputs are registered. s_out shows the start bit on the first cycle after the handshake edge.
- Frame length is (WIDTH+2)*BIT_CYCLES cycles (add BIT_CYCLES when parity is enabled).
- in_ready=0 whenever busy=1. in_valid during a frame is ignored, and the word is neither lost nor latched; the producer must hold it.
- Back-to-back frames: in the done cycle the controller is in IDLE with in_ready=1. If in_valid=1 in that cycle, the next START begins the following cycle. The minimum gap is one idle cycle of s_out=1.
- Cycle counter:
  - Counts 0..BIT_CYCLES-1 and wraps at each bit boundary.
  - With BIT_CYCLES=1 it is constant and each bit lasts one cycle.
- Bit counter: width is clog2(WIDTH+1). It is cleared on entry to DATA and never wraps within a frame.
- in_data X/Z is irrelevant outside the handshake cycle.

Optional Feature:
- Macro: SISO_FRAME_PARITY_EN.
- Defined:
  - A PARITY state follows DATA and drives s_out = even parity (XOR of all WIDTH latched bits) for BIT_CYCLES cycles.
  - Frame length becomes (WIDTH+3)*BIT_CYCLES.
  - The parity bit is computed from the word latched at the handshake.
- Undefined: no PARITY state, no parity logic, and the frame is exactly as described above.

Test Plan:
- Frame 0xA5, WIDTH=8, BIT_CYCLES=1:
  - Stimulus: rst=1 for 2 cycles, then in_valid=1 with 0xA5 for one cycle.
  - Response: s_out over the next 10 cycles = 0,1,0,1,0,0,1,0,1,1; then done=1 for one cycle; busy=1 for exactly 10 cycles; in_ready=0 throughout.
- Busy rejection: while sending 0xA5, present in_valid=1 with 0x3C for 4 mid-frame cycles -> in_ready stays 0 and the s_out sequence is unchanged from the 0xA5 case.
- Back-to-back:
  - Stimulus: hold in_valid=1 with 0xFF, then 0x00 asserted in the done cycle.
  - Response: the second start bit appears 1 cycle after done. The second frame's s_out = 0, then 0 x8, then 1.
- Bit period, BIT_CYCLES=3, word 0x80: start low for 3 cycles, data MSB high for 3 cycles, then 21 cycles low, stop high for 3 cycles; total busy = 30 cycles.
- Reset mid-frame: assert rst for 1 cycle at the 5th data bit of 0xA5 -> next cycle s_out=1, busy=0, in_ready=1; no done pulse ever follows.
- Parity (SISO_FRAME_PARITY_EN defined):
  - 0xA5 -> parity bit 0, frame 0,10100101,0,1.
  - 0x07 -> parity bit 1.
  - Both frames are 11 cycles long.

Source files
------------

// File: rtl/siso_frame_ctrl.sv
// Framed serial transmitter: start bit, WIDTH data bits MSB first, stop bit, each held BIT_CYCLES clocks.
// Define SISO_FRAME_PARITY_EN to insert an even-parity bit between the data and stop bits.
module siso_frame_ctrl #(
    parameter int WIDTH      = 8,
    parameter int BIT_CYCLES = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    output logic             s_out,
    output logic             busy,
    output logic             done
);

    localparam int CW = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
    localparam int BW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] CYC_LAST = CW'(BIT_CYCLES - 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH - 1);

`ifdef SISO_FRAME_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
`endif

    state_t           state;
    logic [CW-1:0]    cyc;
    logic [BW-1:0]    bit_cnt;
    logic [WIDTH-1:0] shreg;
    logic             bit_end;
`ifdef SISO_FRAME_PARITY_EN
    logic             par;
`endif

    assign bit_end = (cyc == CYC_LAST);

    // s_out is loaded with the value of the state being entered, so the line changes on the transition edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            s_out    <= 1'b1;
            in_ready <= 1'b1;
            busy     <= 1'b0;
            done     <= 1'b0;
            cyc      <= '0;
            bit_cnt  <= '0;
            shreg    <= '0;
`ifdef SISO_FRAME_PARITY_EN
            par      <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        shreg    <= in_data;
`ifdef SISO_FRAME_PARITY_EN
                        par      <= ^in_data;
`endif
                        state    <= START;
                        s_out    <= 1'b0;
                        busy     <= 1'b1;
                        in_ready <= 1'b0;
                        cyc      <= '0;
                    end
                end
                START: begin
                    if (bit_end) begin
                        cyc     <= '0;
                        bit_cnt <= '0;
                        state   <= DATA;
                        s_out   <= shreg[WIDTH-1];
                    end else begin
                        cyc <= cyc + CW'(1);
                    end
                end
                DATA: begin
                    if (bit_end) begin
                        cyc     <= '0;
                        shreg   <= shreg << 1;
                        bit_cnt <= bit_cnt + BW'(1);
                        if (bit_cnt == BIT_LAST) begin
`ifdef SISO_FRAME_PARITY_EN
                            state <= PARITY;
                            s_out <= par;
`else
                            state <= STOP;
                            s_out <= 1'b1;
`endif
                        end else begin
                            s_out <= shreg[WIDTH-2];
                        end
                    end else begin
                        cyc <= cyc + CW'(1);
                    end
                end
`ifdef SISO_FRAME_PARITY_EN
                PARITY: begin
                    if (bit_end) begin
                        cyc   <= '0;
                        state <= STOP;
                        s_out <= 1'b1;
                    end else begin
                        cyc <= cyc + CW'(1);
                    end
                end
`endif
                STOP: begin
                    if (bit_end) begin
                        cyc      <= '0;
                        state    <= IDLE;
                        s_out    <= 1'b1;
                        busy     <= 1'b0;
                        in_ready <= 1'b1;
                        done     <= 1'b1;
                    end else begin
                        cyc <= cyc + CW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_siso_frame_ctrl.sv
module tb_siso_frame_ctrl;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         vld [2];
  logic [W-1:0] dat [2];
  logic         so  [2];
  logic         bsy [2];
  logic         rdy [2];
  logic         dn  [2];
  int           n_tests = 0;
  int           n_fail  = 0;
  bit           armed   = 1'b0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : lane
    localparam int BC = (g == 0) ? 1 : 3;
    logic [3:0] q[$];

    siso_frame_ctrl #(.WIDTH(W), .BIT_CYCLES(BC)) dut (
      .clk     (clk),
      .rst     (rst),
      .in_valid(vld[g]),
      .in_data (dat[g]),
      .in_ready(rdy[g]),
      .s_out   (so[g]),
      .busy    (bsy[g]),
      .done    (dn[g])
    );

    task automatic push_bit(input logic b);
      for (int unsigned i = 0; i < BC; i++) q.push_back({b, 1'b1, 1'b0, 1'b0});
    endtask

    always @(posedge clk) begin
      logic [W-1:0] w;
      if (rst) begin
        q.delete();
      end else if (armed && vld[g] && q.size() == 0) begin
        w = dat[g];
        push_bit(1'b0);
        for (int unsigned i = 0; i < W; i++) push_bit(w[W-1-i]);
`ifdef SISO_FRAME_PARITY_EN
        push_bit(^w);
`endif
        push_bit(1'b1);
        q.push_back(4'b1011);
      end
    end

    always @(negedge clk) begin
      logic [3:0] e;
      logic [3:0] a;
      if (armed) begin
        if (q.size() > 0) e = q.pop_front();
        else e = 4'b1010;
        a = {so[g], bsy[g], rdy[g], dn[g]};
        n_tests++;
        if (a !== e) begin
          n_fail++;
          $display("FAIL lane%0d (BIT_CYCLES=%0d) t=%0t {s_out,busy,in_ready,done}: got %b expected %b",
                   g, BC, $time, a, e);
        end
      end
    end
  end

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic check_reset_state();
    for (int unsigned k = 0; k < 2; k++) begin
      n_tests++;
      if ({so[k], bsy[k], rdy[k], dn[k]} !== 4'b1010) begin
        n_fail++;
        $display("FAIL reset state lane%0d t=%0t {s_out,busy,in_ready,done}: got %b expected 1010",
                 k, $time, {so[k], bsy[k], rdy[k], dn[k]});
      end
    end
  endtask

  task automatic wait_done0(input int unsigned max_cycles);
    bit seen;
    seen = 1'b0;
    for (int unsigned c = 0; c < max_cycles; c++) begin
      step();
      if (dn[0] === 1'b1) seen = 1'b1;
    end
    n_tests++;
    if (!seen) begin
      n_fail++;
      $display("FAIL lane0 t=%0t: done not seen within %0d cycles", $time, max_cycles);
    end
  endtask

  initial begin
    rst = 1'b1;
    for (int unsigned k = 0; k < 2; k++) begin
      vld[k] = 1'b0;
      dat[k] = '0;
    end
    step(2);
    check_reset_state();
    armed = 1'b1;
    rst   = 1'b0;
    step(2);

    vld[0] = 1'b1; dat[0] = 8'hA5;
    step();
    vld[0] = 1'b0;
    wait_done0(14);

    vld[0] = 1'b1; dat[0] = 8'hA5;
    step();
    vld[0] = 1'b0;
    step(2);
    vld[0] = 1'b1; dat[0] = 8'h3C;
    step(4);
    vld[0] = 1'b0;
    step(10);

    vld[0] = 1'b1; dat[0] = 8'hFF;
    step();
    dat[0] = 8'h00;
    step(11);
    vld[0] = 1'b0;
    step(14);

    vld[0] = 1'b1; dat[0] = 8'hA5;
    step();
    vld[0] = 1'b0;
    step(5);
    rst = 1'b1;
    step();
    rst = 1'b0;
    step(14);

    vld[1] = 1'b1; dat[1] = 8'h80;
    step();
    vld[1] = 1'b0;
    step(36);

    vld[0] = 1'b1; dat[0] = 8'h07;
    vld[1] = 1'b1; dat[1] = 8'hA5;
    step();
    vld[0] = 1'b0; vld[1] = 1'b0;
    step(40);

    for (int unsigned i = 0; i < 800; i++) begin
      for (int unsigned k = 0; k < 2; k++) begin
        vld[k] = ($urandom_range(0, 2) != 0);
        dat[k] = W'($urandom);
      end
      rst = ($urandom_range(0, 199) == 0);
      step();
    end
    rst = 1'b0;
    vld[0] = 1'b0; vld[1] = 1'b0;
    step(45);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
